// File: rtl/bp_resolver_pkg.sv
// rtl/bp_resolver_pkg.sv - shared branch-predictor types, encodings and defaults
package bp_resolver_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_IDX_W = 4;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rslv_state_t;

  // 2-bit saturating counter states held in the predictor table
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_state_t;

  function automatic logic ctr_taken(input ctr_state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// rtl/bp_pred_fifo.sv - in-flight prediction FIFO of {taken, idx} with synchronous clear
module bp_pred_fifo
  import bp_resolver_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             push_taken,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  input  logic             clear,
  output logic             head_taken,
  output logic [IDX_W-1:0] head_idx,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [IDX_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= {push_taken, push_idx};
    end
  end

  // Clear wins over push/pop so a flush drops a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_taken = mem[rd_ptr][IDX_W];
  assign head_idx   = mem[rd_ptr][IDX_W-1:0];
  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);

endmodule

// File: rtl/bp_resolver.sv
// rtl/bp_resolver.sv - matches resolved branches against queued predictions, drives table updates and flushes
module bp_resolver
  import bp_resolver_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_en,
  output logic             upd_actual,
  output logic [IDX_W-1:0] upd_idx,
  output logic             mispredict,
  output logic             underflow,
  output logic [CNT_W-1:0] mispredict_cnt
);

  rslv_state_t      state;
  rslv_state_t      state_nxt;
  logic             head_taken;
  logic [IDX_W-1:0] head_idx;
  logic             full;
  logic             empty;
  logic             pop_req;
  logic             mis;
  logic             push;

  assign pop_req = (state == RUN) && res_valid && !empty;
  assign mis     = pop_req && (head_taken != res_taken);
  assign push    = pred_valid && pred_ready && !mis;

  bp_pred_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_taken (pred_taken),
    .push_idx   (pred_idx),
    .pop        (pop_req),
    .clear      (mis),
    .head_taken (head_taken),
    .head_idx   (head_idx),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pred_ready = 1'b0;
    case (state)
      RUN: begin
        pred_ready = !full;
        if (mis) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_en         <= 1'b0;
      upd_actual     <= 1'b0;
      upd_idx        <= '0;
      mispredict     <= 1'b0;
      underflow      <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      upd_en     <= pop_req;
      mispredict <= mis;
      if (pop_req) begin
        upd_actual <= res_taken;
        upd_idx    <= head_idx;
      end
      if ((state == RUN) && res_valid && empty) underflow <= 1'b1;
      if (mis && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule
